// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reset_sequencer_if : lock/request inputs and staged reset outputs of the
// reset sequencer.  Rev 1.0
// ----------------------------------------------------------------------------
interface reset_sequencer_if #(
  parameter int CHANNELS = 4
);
  logic                iPLL_LOCKED;
  logic                iSOFT_RST;
  logic                iWDT_KICK;
  logic [CHANNELS-1:0] oRESETn;
  logic                oDONE;
  logic                oWDT_TRIP;

  modport master (
    output iPLL_LOCKED, iSOFT_RST, iWDT_KICK,
    input  oRESETn, oDONE, oWDT_TRIP
  );

  modport slave (
    input  iPLL_LOCKED, iSOFT_RST, iWDT_KICK,
    output oRESETn, oDONE, oWDT_TRIP
  );
endinterface
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reset_sequencer : filtered PLL lock, global hold, then in-order release of
// CHANNELS active-low resets. Optional watchdog: RESET_SEQ_WATCHDOG_EN. Rev 1.0
// ----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int CHANNELS    = 4,
  parameter int LOCK_FILTER = 4,
  parameter int HOLD_CYCLES = 32,
  parameter int STAGE_GAP   = 8,
  parameter int WDT_CYCLES  = 1024
) (
  input  logic             iCLK,
  input  logic             iRESETn,
  reset_sequencer_if.slave bus
);

  localparam int LCW = $clog2(LOCK_FILTER) + 1;
  localparam int HCW = $clog2(HOLD_CYCLES) + 1;
  localparam int GCW = $clog2(STAGE_GAP) + 1;
  localparam int ICW = $clog2(CHANNELS) + 1;
  localparam int WCW = $clog2(WDT_CYCLES) + 1;

  localparam logic [LCW-1:0] LOCK_MAX  = LCW'(LOCK_FILTER);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'(STAGE_GAP - 1);
  localparam logic [ICW-1:0] IDX_LAST  = ICW'(CHANNELS - 1);
  localparam logic [WCW-1:0] WDT_LAST  = WCW'(WDT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [LCW-1:0]      lock_cnt_q, lock_cnt_d;
  logic [HCW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [GCW-1:0]      gap_cnt_q, gap_cnt_d;
  logic [ICW-1:0]      idx_q, idx_d;
  logic [CHANNELS-1:0] rst_n_q, rst_n_d;
  logic                done_q, done_d;
  logic                lock_ok;
  logic                wdt_expire;

`ifdef RESET_SEQ_WATCHDOG_EN
  logic [WCW-1:0]      wdt_cnt_q, wdt_cnt_d;
  logic                trip_q, trip_d;

  always_comb begin
    wdt_cnt_d  = '0;
    wdt_expire = 1'b0;
    if (state_q == ST_RUN) begin
      if (bus.iWDT_KICK) begin
        wdt_cnt_d = '0;
      end else if (wdt_cnt_q == WDT_LAST) begin
        wdt_expire = 1'b1;
      end else begin
        wdt_cnt_d = wdt_cnt_q + 1'b1;
      end
    end
  end
`else
  logic unused_wdt;
  assign unused_wdt = bus.iWDT_KICK ^ WDT_LAST[0];
  assign wdt_expire = 1'b0;
`endif

  assign lock_ok = bus.iPLL_LOCKED && !bus.iSOFT_RST;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    idx_d      = idx_q;
    rst_n_d    = rst_n_q;
    done_d     = done_q;

    case (state_q)
      ST_WAIT_LOCK: begin
        rst_n_d = '0;
        done_d  = 1'b0;
        if (!lock_ok) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_MAX) begin
          state_d    = ST_HOLD;
          lock_cnt_d = '0;
          hold_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_RELEASE;
          hold_cnt_d = '0;
          gap_cnt_d  = '0;
          idx_d      = '0;
          rst_n_d[0] = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (idx_q == IDX_LAST) begin
          state_d   = ST_RUN;
          done_d    = 1'b1;
          gap_cnt_d = '0;
          idx_d     = '0;
        end else if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          idx_d     = idx_q + 1'b1;
          rst_n_d   = rst_n_q | (CHANNELS'(1) << idx_d);
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        rst_n_d = '1;
        done_d  = 1'b1;
      end
      default: state_d = ST_WAIT_LOCK;
    endcase

    // Abort and watchdog expiry override whatever the state wanted this cycle.
    if (((state_q != ST_WAIT_LOCK) && !lock_ok) || wdt_expire) begin
      state_d    = ST_WAIT_LOCK;
      lock_cnt_d = '0;
      hold_cnt_d = '0;
      gap_cnt_d  = '0;
      idx_d      = '0;
      rst_n_d    = '0;
      done_d     = 1'b0;
    end
  end

`ifdef RESET_SEQ_WATCHDOG_EN
  assign trip_d = wdt_expire && lock_ok;
`endif

  always_ff @(posedge iCLK) begin
    if (!iRESETn) begin
      state_q    <= ST_WAIT_LOCK;
      lock_cnt_q <= '0;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      idx_q      <= '0;
      rst_n_q    <= '0;
      done_q     <= 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
      wdt_cnt_q  <= '0;
      trip_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      idx_q      <= idx_d;
      rst_n_q    <= rst_n_d;
      done_q     <= done_d;
`ifdef RESET_SEQ_WATCHDOG_EN
      wdt_cnt_q  <= wdt_cnt_d;
      trip_q     <= trip_d;
`endif
    end
  end

  assign bus.oRESETn = rst_n_q;
  assign bus.oDONE   = done_q;
`ifdef RESET_SEQ_WATCHDOG_EN
  assign bus.oWDT_TRIP = trip_q;
`else
  assign bus.oWDT_TRIP = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_reset_sequencer : scoreboard bench; expected output changes are queued
// with their edge index and matched as the DUT outputs change.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_reset_sequencer;

  typedef struct {
    int         cyc;
    logic [5:0] val;
  } ev_t;

  logic clk;
  logic rstn0, rstn1;
  int   edge_n = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;
  logic mon_en = 1'b0;
  logic [5:0] last0 = '0;
  logic [5:0] last1 = '0;
  ev_t  q0[$];
  ev_t  q1[$];

  reset_sequencer_if #(.CHANNELS(4)) bus0 ();
  reset_sequencer_if #(.CHANNELS(1)) bus1 ();

  reset_sequencer #(.WDT_CYCLES(16)) dut0 (
    .iCLK    (clk),
    .iRESETn (rstn0),
    .bus     (bus0)
  );

  reset_sequencer #(.CHANNELS(1), .HOLD_CYCLES(1), .STAGE_GAP(1), .WDT_CYCLES(16)) dut1 (
    .iCLK    (clk),
    .iRESETn (rstn1),
    .bus     (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #200000;
    $display("FAIL timeout: edge %0d reached, required finish", edge_n);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic push0(input int c, input logic [3:0] r, input logic d, input logic t);
    ev_t e;
    e.cyc = c;
    e.val = {r, d, t};
    q0.push_back(e);
  endtask

  task automatic push1(input int c, input logic r, input logic d, input logic t);
    ev_t e;
    e.cyc = c;
    e.val = {3'b000, r, d, t};
    q1.push_back(e);
  endtask

  // Release schedule for dut0 given the edge index of T0; nbits < 4 stops early.
  task automatic seq0(input int t0, input int nbits);
    for (int k = 0; k < nbits; k++)
      push0(t0 + 36 + 8 * k, 4'((1 << (k + 1)) - 1), 1'b0, 1'b0);
    if (nbits == 4) push0(t0 + 61, 4'hF, 1'b1, 1'b0);
  endtask

  task automatic wait_edge(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  // Returns at the negedge before edge e, so inputs driven next are sampled at e.
  task automatic at_edge(input int e);
    wait_edge(e - 1);
  endtask

  always @(negedge clk) begin
    logic [5:0] cur;
    ev_t        e;
    if (mon_en) begin
      cur = {bus0.oRESETn, bus0.oDONE, bus0.oWDT_TRIP};
      if (cur !== last0) begin
        check("pending0", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          check("edge0", edge_n, e.cyc);
          check("value0", 32'(cur), 32'(e.val));
        end
        last0 <= cur;
      end
    end
  end

  always @(negedge clk) begin
    logic [5:0] cur;
    ev_t        e;
    if (mon_en) begin
      cur = {3'b000, bus1.oRESETn, bus1.oDONE, bus1.oWDT_TRIP};
      if (cur !== last1) begin
        check("pending1", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          check("edge1", edge_n, e.cyc);
          check("value1", 32'(cur), 32'(e.val));
        end
        last1 <= cur;
      end
    end
  end

  initial begin
    int t0, r, r2, s;
    rstn0 = 1'b0;
    rstn1 = 1'b0;
    bus0.iPLL_LOCKED = 1'b0;
    bus0.iSOFT_RST   = 1'b0;
    bus0.iWDT_KICK   = 1'b1;
    bus1.iPLL_LOCKED = 1'b0;
    bus1.iSOFT_RST   = 1'b0;
    bus1.iWDT_KICK   = 1'b1;

    // Reset state
    wait_edge(3);
    check("rst0_resetn", 32'(bus0.oRESETn), 32'h0);
    check("rst0_done",   32'(bus0.oDONE), 32'h0);
    check("rst0_trip",   32'(bus0.oWDT_TRIP), 32'h0);
    check("rst1_resetn", 32'(bus1.oRESETn), 32'h0);
    check("rst1_done",   32'(bus1.oDONE), 32'h0);
    mon_en = 1'b1;

    // Power-up with lock held high from T0, both instances
    t0 = edge_n + 1;
    rstn0 = 1'b1;
    rstn1 = 1'b1;
    bus0.iPLL_LOCKED = 1'b1;
    bus1.iPLL_LOCKED = 1'b1;
    seq0(t0, 4);
    push1(t0 + 5, 1'b1, 1'b0, 1'b0);
    push1(t0 + 6, 1'b1, 1'b1, 1'b0);
    wait_edge(t0 + 70);
    check("drain_powerup0", q0.size(), 0);
    check("drain_powerup1", q1.size(), 0);

    // One-cycle lock glitch inside WAIT_LOCK restarts the filter
    s = edge_n + 1;
    at_edge(s);
    bus0.iPLL_LOCKED = 1'b0;
    push0(s, 4'h0, 1'b0, 1'b0);
    t0 = s + 5;
    at_edge(t0);
    bus0.iPLL_LOCKED = 1'b1;
    at_edge(t0 + 2);
    bus0.iPLL_LOCKED = 1'b0;
    at_edge(t0 + 3);
    bus0.iPLL_LOCKED = 1'b1;
    seq0(t0 + 3, 4);
    wait_edge(t0 + 3 + 70);
    check("drain_glitch", q0.size(), 0);

    // Lock loss mid-release, then relock
    s = edge_n + 1;
    at_edge(s);
    bus0.iPLL_LOCKED = 1'b0;
    push0(s, 4'h0, 1'b0, 1'b0);
    t0 = s + 3;
    at_edge(t0);
    bus0.iPLL_LOCKED = 1'b1;
    seq0(t0, 2);
    at_edge(t0 + 48);
    bus0.iPLL_LOCKED = 1'b0;
    push0(t0 + 48, 4'h0, 1'b0, 1'b0);
    at_edge(t0 + 50);
    bus0.iPLL_LOCKED = 1'b1;
    seq0(t0 + 50, 4);
    wait_edge(t0 + 50 + 70);
    check("drain_lockloss", q0.size(), 0);

    // Soft reset held for 10 cycles in RUN
    s = edge_n + 1;
    at_edge(s);
    bus0.iSOFT_RST = 1'b1;
    push0(s, 4'h0, 1'b0, 1'b0);
    at_edge(s + 10);
    bus0.iSOFT_RST = 1'b0;
    seq0(s + 10, 4);
    wait_edge(s + 10 + 70);
    check("drain_soft", q0.size(), 0);

    // Synchronous reset in the middle of RELEASE
    s = edge_n + 1;
    at_edge(s);
    bus0.iPLL_LOCKED = 1'b0;
    push0(s, 4'h0, 1'b0, 1'b0);
    t0 = s + 3;
    at_edge(t0);
    bus0.iPLL_LOCKED = 1'b1;
    seq0(t0, 2);
    at_edge(t0 + 46);
    rstn0 = 1'b0;
    push0(t0 + 46, 4'h0, 1'b0, 1'b0);
    wait_edge(t0 + 49);
    check("midrst_resetn", 32'(bus0.oRESETn), 32'h0);
    check("midrst_done",   32'(bus0.oDONE), 32'h0);
    at_edge(t0 + 50);
    rstn0 = 1'b1;
    seq0(t0 + 50, 4);
    r = t0 + 50 + 61;
    at_edge(r - 6);
    bus0.iWDT_KICK = 1'b0;

`ifdef RESET_SEQ_WATCHDOG_EN
    // No kicks: trip 16 cycles after RUN entry, then a full restart
    push0(r + 16, 4'h0, 1'b0, 1'b1);
    push0(r + 17, 4'h0, 1'b0, 1'b0);
    seq0(r + 17, 4);
    r2 = r + 17 + 61;
    wait_edge(r2 + 1);
    check("drain_wdt_trip", q0.size(), 0);
    // Kicks every 10 cycles keep it running
    for (int i = 0; i < 6; i++) begin
      at_edge(r2 + 5 + 10 * i);
      bus0.iWDT_KICK = 1'b1;
      at_edge(r2 + 6 + 10 * i);
      bus0.iWDT_KICK = 1'b0;
    end
    wait_edge(r2 + 62);
    check("wdt_kick_done", 32'(bus0.oDONE), 32'h1);
    check("wdt_kick_trip", 32'(bus0.oWDT_TRIP), 32'h0);
    check("drain_wdt_kick", q0.size(), 0);
`else
    // Without the watchdog, no kicks must never disturb RUN
    r2 = r + 40;
    wait_edge(r2);
    check("nowdt_done", 32'(bus0.oDONE), 32'h1);
    check("nowdt_trip", 32'(bus0.oWDT_TRIP), 32'h0);
    check("nowdt_resetn", 32'(bus0.oRESETn), 32'hF);
    check("drain_nowdt", q0.size(), 0);
`endif

    check("final1_done", 32'(bus1.oDONE), 32'h1);
    check("drain_final1", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
